// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode constants, fetch state encoding and default widths
package proc_pkg;

    localparam int ADDR_W = 4;
    localparam int WORD_W = 8;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_LOAD  = 4'b0101;
    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory bus plus downstream instruction handshake
interface instr_fetch_unit_if #(
    parameter int ADDR_W = proc_pkg::ADDR_W,
    parameter int WORD_W = proc_pkg::WORD_W
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_rdata;
    logic              imem_valid;
    logic [3:0]        instr_out;
    logic [3:0]        operand_out;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output imem_req, imem_addr, instr_out, operand_out, instr_valid, pc_out,
        input  imem_rdata, imem_valid, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, operand_out, instr_valid, pc_out,
        output imem_rdata, imem_valid, instr_ready
    );
endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with synchronous reset, wrapping increment and parallel load
module program_counter #(
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Load wins over increment; the increment wraps naturally at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, memory read, HALT handling, valid/ready opcode issue
// Define INSTR_FETCH_JUMP_EN to resolve OP_JMP locally instead of passing it downstream.
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int ADDR_W = proc_pkg::ADDR_W,
    parameter int WORD_W = proc_pkg::WORD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                resume,
    instr_fetch_unit_if.master  bus,
    output logic                halted
);
    fetch_state_e      state_q, state_d;
    logic              imem_req_q, imem_req_d;
    logic [3:0]        instr_q, instr_d;
    logic [3:0]        operand_q, operand_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              halted_q, halted_d;

    logic              pc_inc;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        rd_op;
    logic [3:0]        rd_operand;

    assign rd_op      = bus.imem_rdata[WORD_W-1 -: 4];
    assign rd_operand = bus.imem_rdata[3:0];

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (pc_inc),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .pc_o       (pc)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        operand_d   = operand_q;
        valid_d     = valid_q;
        pc_out_d    = pc_out_q;
        halted_d    = halted_q;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_valid) begin
                    if (rd_op == OP_HALT) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
`ifdef INSTR_FETCH_JUMP_EN
                    else if (rd_op == OP_JMP) begin
                        pc_load     = 1'b1;
                        pc_load_val = ADDR_W'(rd_operand);
                        state_d     = ST_REQ;
                    end
`endif
                    else begin
                        instr_d   = rd_op;
                        operand_d = rd_operand;
                        pc_out_d  = pc;
                        valid_d   = 1'b1;
                        pc_inc    = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    state_d = run ? ST_REQ : ST_IDLE;
                end
            end
            ST_HALT: begin
                // Step past the HALT word so the restart fetches the next instruction.
                if (resume) begin
                    halted_d = 1'b0;
                    pc_inc   = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        imem_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            imem_req_q <= 1'b0;
            instr_q    <= OP_NOP;
            operand_q  <= '0;
            valid_q    <= 1'b0;
            pc_out_q   <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            instr_q    <= instr_d;
            operand_q  <= operand_d;
            valid_q    <= valid_d;
            pc_out_q   <= pc_out_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc;
    assign bus.instr_out   = instr_q;
    assign bus.operand_out = operand_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pc_out_q;
    assign halted          = halted_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import proc_pkg::*;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] opd;
        logic [3:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic run;
    logic resume;
    logic halted;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .resume (resume),
        .bus    (bus),
        .halted (halted)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         cycle = 0;
    int         req_count = 0;
    logic [7:0] mem [16];
    exp_t       exp_q [$];
    logic [3:0] addr_q [$];
    int         hs_q [$];
    exp_t       mon_e;
    logic [3:0] mon_a;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory model: answer each request one cycle later with a single-cycle valid.
    initial begin : responder
        logic [3:0] a;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin
                a = bus.imem_addr;
                @(posedge clk);
                #1;
                bus.imem_valid = 1'b1;
                bus.imem_rdata = mem[a];
                @(posedge clk);
                #1;
                bus.imem_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin
                req_count++;
                vectors++;
                if (addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_req addr=%0d required no request", bus.imem_addr);
                end else begin
                    mon_a = addr_q.pop_front();
                    if (bus.imem_addr !== mon_a) begin
                        miscompares++;
                        $display("FAIL req_addr got=%0d required=%0d", bus.imem_addr, mon_a);
                    end
                end
            end
            if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
                hs_q.push_back(cycle);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_instr op=%h opd=%h pc=%0d required none",
                             bus.instr_out, bus.operand_out, bus.pc_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({bus.instr_out, bus.operand_out, bus.pc_out} !== mon_e) begin
                        miscompares++;
                        $display("FAIL instr got op=%h opd=%h pc=%0d required op=%h opd=%h pc=%0d",
                                 bus.instr_out, bus.operand_out, bus.pc_out,
                                 mon_e.op, mon_e.opd, mon_e.pc);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        resume = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        addr_q.delete();
        hs_q.delete();
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_halted(input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_timeout halted=%b required=1", halted);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_out, bus.operand_out,
             bus.instr_valid, bus.pc_out, halted} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_values req=%b addr=%0d op=%h opd=%h valid=%b pc=%0d halted=%b required all 0",
                     bus.imem_req, bus.imem_addr, bus.instr_out, bus.operand_out,
                     bus.instr_valid, bus.pc_out, halted);
        end
    endtask

    task automatic test_basic_halt_resume();
        int rc;
        do_reset();
        mem[0] = 8'h13;
        mem[1] = 8'h25;
        mem[2] = 8'hF0;
        exp_q.push_back('{4'h1, 4'h3, 4'd0});
        exp_q.push_back('{4'h2, 4'h5, 4'd1});
        addr_q.push_back(4'd0);
        addr_q.push_back(4'd1);
        addr_q.push_back(4'd2);
        run = 1'b1;
        wait_halted(40);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_pending got=%0d required=0", exp_q.size());
        end
        vectors++;
        if (hs_q.size() != 2 || (hs_q.size() == 2 && hs_q[1] - hs_q[0] != 3)) begin
            miscompares++;
            $display("FAIL valid_spacing handshakes=%0d gap=%0d required 2 handshakes gap=3",
                     hs_q.size(), (hs_q.size() == 2) ? hs_q[1] - hs_q[0] : -1);
        end
        rc = req_count;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (req_count != rc || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_idle reqs=%0d halted=%b required reqs=%0d halted=1", req_count, halted, rc);
        end
        mem[3] = 8'h34;
        mem[4] = 8'h7A;
        exp_q.push_back('{4'h3, 4'h4, 4'd3});
        addr_q.push_back(4'd3);
        addr_q.push_back(4'd4);
`ifdef INSTR_FETCH_JUMP_EN
        addr_q.push_back(4'hA);
`else
        exp_q.push_back('{4'h7, 4'hA, 4'd4});
        addr_q.push_back(4'd5);
`endif
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        vectors++;
        if (halted !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_halted got=%b required=0", halted);
        end
        wait_halted(60);
        vectors++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL jmp_pending instr=%0d addr=%0d required 0 0", exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_hold_stall();
        int rc;
        int n = 0;
        do_reset();
        mem[0] = 8'h56;
        exp_q.push_back('{4'h5, 4'h6, 4'd0});
        addr_q.push_back(4'd0);
        addr_q.push_back(4'd1);
        bus.instr_ready = 1'b0;
        run = 1'b1;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        rc = req_count;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({bus.instr_out, bus.operand_out, bus.pc_out, bus.instr_valid} !== {4'h5, 4'h6, 4'd0, 1'b1}
                || req_count != rc) begin
                miscompares++;
                $display("FAIL hold_stable cyc=%0d op=%h opd=%h pc=%0d valid=%b reqs=%0d required 5 6 0 1 reqs=%0d",
                         c, bus.instr_out, bus.operand_out, bus.pc_out, bus.instr_valid, req_count, rc);
            end
        end
        bus.instr_ready = 1'b1;
        wait_halted(20);
        vectors++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL hold_pending instr=%0d addr=%0d required 0 0", exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_pc_wrap();
        int n = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i] = {4'(i % 7), 4'(15 - i)};
            exp_q.push_back('{4'(i % 7), 4'(15 - i), 4'(i)});
            addr_q.push_back(4'(i));
        end
        addr_q.push_back(4'd0);
        run = 1'b1;
        while (exp_q.size() == 16 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        mem[0] = 8'hF0;
        wait_halted(100);
        vectors++;
        if (exp_q.size() != 0 || addr_q.size() != 0 || bus.imem_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL pc_wrap instr=%0d addr_left=%0d pc=%0d required 0 0 0",
                     exp_q.size(), addr_q.size(), bus.imem_addr);
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        mem[0] = 8'h19;
        exp_q.push_back('{4'h1, 4'h9, 4'd0});
        addr_q.push_back(4'd0);
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0 || addr_q.size() != 0 || bus.instr_valid !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL run_drop instr=%0d addr=%0d valid=%b halted=%b required 0 0 0 0",
                     exp_q.size(), addr_q.size(), bus.instr_valid, halted);
        end
    endtask

    task automatic test_reset_in_wait();
        int n = 0;
        do_reset();
        mem[0] = 8'h13;
        addr_q.push_back(4'd0);
        run = 1'b1;
        while (bus.imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_out, bus.operand_out,
             bus.instr_valid, bus.pc_out, halted} !== 19'h0) begin
            miscompares++;
            $display("FAIL wait_reset req=%b addr=%0d op=%h opd=%h valid=%b pc=%0d halted=%b required all 0",
                     bus.imem_req, bus.imem_addr, bus.instr_out, bus.operand_out,
                     bus.instr_valid, bus.pc_out, halted);
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b0 || addr_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wait_reset_drop valid=%b addr_left=%0d required valid=0 addr_left=0",
                     bus.instr_valid, addr_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        resume = 1'b0;
        bus.instr_ready = 1'b1;
        test_reset();
        test_basic_halt_resume();
        test_hold_stall();
        test_pc_wrap();
        test_run_drop();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
